conv_result_serializer: RTL and testbench
=========================================

CONV_RESULT_SERIALIZER -- requirements
Module: conv_result_serializer

Interface
REQ-001 SHALL have parameter: LATENCY, 8, clock edges from accepted start to valid 160-bit convolution result (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle pulse marking the cycle new A/B operands enter the convolution stage.
REQ-005 SHALL have port: result  input  160  five packed IEEE-754 single words: word0 = [159:128] ... word4 = [31:0].
REQ-006 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port: out_data  output  32  current result word.
REQ-009 SHALL have port: out_index  output  3  index (0..4) of word on out_data.
REQ-010 SHALL have port: out_last  output  1  high with out_valid when out_index==4.
REQ-011 SHALL have port: busy  output  1  high in WAIT or SEND.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after word4 handshake.
REQ-013 SHALL have port: overrun  output  1  one-cycle pulse when start arrives while busy.
REQ-014 SHALL have port: nan_flag  output  1  sticky NaN indicator (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SEND.
REQ-016 IDLE: start=1 -> WAIT, load 8-bit countdown with LATENCY-1.
REQ-017 WAIT: countdown decrements each edge; at the edge where countdown==0, capture result into a 160-bit holding register, set out_index=0, -> SEND (capture edge = start edge + LATENCY).
REQ-018 SEND: out_valid=1, out_data = held word[out_index]; word0 first, word4 last.
REQ-019 Handshake completes on edge with out_valid && out_ready; out_index increments by 1.
REQ-020 out_data, out_index, out_last SHALL stay stable while out_valid && !out_ready.
REQ-021 Handshake at out_index==4 -> IDLE, out_valid=0 next cycle, done=1 for exactly that next cycle.
REQ-022 start in WAIT or SEND SHALL be ignored (no restart, held data unchanged) and pulse overrun for one cycle.
REQ-023 start in IDLE SHALL not pulse overrun; start coinciding with final handshake is treated as busy (ignored, overrun).
REQ-024 result input SHALL be sampled only at the capture edge; changes at other times have no effect.
REQ-025 Throughput: five words in five cycles with out_ready held high.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE; out_valid, out_data, out_index, out_last, busy, done, overrun, nan_flag, countdown, holding register all 0.
REQ-027 Reset mid-WAIT or mid-SEND SHALL discard pending/captured data; no done pulse.

Configuration
REQ-028 Macro CONV_SER_NAN_CHECK_EN defined: at capture, nan_flag sets if any word has exponent 8'hFF and mantissa !=0; cleared by accepted start or reset; otherwise holds.
REQ-029 Macro undefined: nan_flag port present, tied 0; no NaN logic synthesized.

Verification
REQ-030 LATENCY=8, start at cycle 0, result={3F800000,40000000,40400000,40800000,40A00000}, out_ready=1 -> capture at edge 8, words 3F800000..40A00000 on cycles 9-13 with out_index 0..4, out_last at 40A00000, done on cycle 14.
REQ-031 Same, out_ready low on cycles 9-11 -> out_data holds 3F800000, out_index 0 until ready; done 5 handshakes later.
REQ-032 Second start 3 cycles after first -> overrun pulses 1 cycle, output sequence of first job unchanged, no second job.
REQ-033 rst asserted during SEND at out_index=2 -> out_valid=0 immediately, busy=0, no done; next start runs normally from word0.
REQ-034 CONV_SER_NAN_CHECK_EN defined, word2=7FC00000 -> nan_flag=1 after capture, stays 1 through done, clears on next accepted start; undefined -> nan_flag always 0.
REQ-035 LATENCY=1, start at cycle 0 -> capture at edge 1, word0 valid cycle 2.

Source files
------------

// File: rtl/conv_result_serializer.sv
// conv_result_serializer: waits LATENCY edges after an accepted start, captures the
// 160-bit convolution result (five IEEE-754 singles) and streams it out one word per
// valid/ready handshake, word0 first.
// Optional feature: define CONV_SER_NAN_CHECK_EN to enable the sticky NaN detector;
// without it nan_flag is tied low and no detection logic exists.
module conv_result_serializer #(
   parameter int unsigned LATENCY = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [159:0] result,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [31:0]  out_data,
   output logic [2:0]   out_index,
   output logic         out_last,
   output logic         busy,
   output logic         done,
   output logic         overrun,
   output logic         nan_flag
);

   localparam logic [7:0] CntInit = 8'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

   state_e         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [159:0]   hold_q, hold_d;
   logic [2:0]     idx_q, idx_d;
   logic           done_q, done_d;
   logic           overrun_q, overrun_d;
   logic [31:0]    word_sel;

   // State, countdown, holding register and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hold_q    <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state logic: accept, count down, capture, then walk the five words
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StWait;
               cnt_d   = CntInit;
            end
         end
         StWait: begin
            // A start while a job is pending is dropped, only flagged
            overrun_d = start;
            if (cnt_q == 8'd0) begin
               hold_d  = result;
               idx_d   = 3'd0;
               state_d = StSend;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSend: begin
            // Includes a start coinciding with the final handshake
            overrun_d = start;
            if (out_ready) begin
               if (idx_q == 3'd4) begin
                  state_d = StIdle;
                  idx_d   = 3'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Word select from the holding register, word0 in the top bits
   always_comb begin
      word_sel = 32'd0;
      case (idx_q)
         3'd0:    word_sel = hold_q[159:128];
         3'd1:    word_sel = hold_q[127:96];
         3'd2:    word_sel = hold_q[95:64];
         3'd3:    word_sel = hold_q[63:32];
         3'd4:    word_sel = hold_q[31:0];
         default: word_sel = 32'd0;
      endcase
   end

   // Output decode; data is zeroed whenever nothing valid is presented
   always_comb begin
      out_valid = (state_q == StSend);
      busy      = (state_q != StIdle);
      out_index = idx_q;
      out_last  = out_valid && (idx_q == 3'd4);
      out_data  = out_valid ? word_sel : 32'd0;
      done      = done_q;
      overrun   = overrun_q;
   end

`ifdef CONV_SER_NAN_CHECK_EN
   logic nan_q;
   logic nan_any;

   // NaN: all-ones exponent with a non-zero mantissa in any of the five words
   always_comb begin
      nan_any = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if ((result[32*i+23 +: 8] == 8'hFF) && (result[32*i +: 23] != 23'd0)) begin
            nan_any = 1'b1;
         end
      end
   end

   // Sticky flag: cleared by an accepted start, set at capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nan_q <= 1'b0;
      end else if ((state_q == StIdle) && start) begin
         nan_q <= 1'b0;
      end else if ((state_q == StWait) && (cnt_q == 8'd0) && nan_any) begin
         nan_q <= 1'b1;
      end
   end

   assign nan_flag = nan_q;
`else
   assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_conv_result_serializer.sv
// Bench for conv_result_serializer: a directed vector table, hand-written corner
// sequences (overrun, reset mid-send, NaN flag, LATENCY=1) and a randomized run checked
// every cycle against a transaction-level model (word queue plus capture-time arithmetic).
module tb_conv_result_serializer;

   localparam int unsigned Lat = 8;
`ifdef CONV_SER_NAN_CHECK_EN
   localparam bit NanEn = 1'b1;
`else
   localparam bit NanEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start, start1;
   logic [159:0] result;
   logic         out_ready, ready1;
   logic         out_valid, out_last, busy, done, overrun, nan_flag;
   logic [31:0]  out_data;
   logic [2:0]   out_index;
   logic         valid1, last1, busy1, done1, ovr1, nan1;
   logic [31:0]  data1;
   logic [2:0]   index1;

   always #5 clk = ~clk;

   conv_result_serializer #(.LATENCY(Lat)) dut (
      .clk(clk), .rst(rst), .start(start), .result(result), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .busy(busy), .done(done), .overrun(overrun),
      .nan_flag(nan_flag)
   );

   conv_result_serializer #(.LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .result(result), .out_ready(ready1),
      .out_valid(valid1), .out_data(data1), .out_index(index1),
      .out_last(last1), .busy(busy1), .done(done1), .overrun(ovr1),
      .nan_flag(nan1)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int          cyc = 0;
   bit          m_active, m_captured, m_done, m_ovr, m_nan;
   int          m_cap_edge;
   logic [31:0] m_q[$];

   function automatic bit has_nan(input logic [159:0] r);
      logic [31:0] w;
      for (int i = 0; i < 5; i++) begin
         w = r[159-32*i -: 32];
         if (w[30:23] == 8'hFF && w[22:0] != 23'd0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_clear();
      m_active = 0; m_captured = 0; m_done = 0; m_ovr = 0; m_nan = 0;
      m_q.delete();
   endtask

   // Advance the model across one rising edge using the inputs sampled at that edge
   task automatic model_step();
      bit hs;
      if (rst) begin
         model_clear();
      end else begin
         hs    = m_active && m_captured && out_ready;
         m_ovr = start && m_active;
         m_done = hs && (m_q.size() == 1);
         if (hs) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_active = 0;
         end else if (m_active && !m_captured && cyc == m_cap_edge) begin
            for (int i = 0; i < 5; i++) m_q.push_back(result[159-32*i -: 32]);
            m_captured = 1;
            if (NanEn && has_nan(result)) m_nan = 1;
         end else if (!m_active && start) begin
            m_active   = 1;
            m_captured = 0;
            m_cap_edge = cyc + int'(Lat);
            m_nan      = 0;
         end
      end
      cyc++;
   endtask

   task automatic check_model();
      bit ve;
      ve = m_active && m_captured;
      chk("model_ctrl", {out_valid, busy, done, overrun, nan_flag, out_last},
          {ve, m_active, m_done, m_ovr, m_nan, ve && (m_q.size() == 1)});
      if (ve) chk("model_word", {out_data, out_index}, {m_q[0], 3'(5 - m_q.size())});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          start;
      bit          ready;
      bit          valid;
      logic [31:0] data;
      logic [2:0]  index;
      bit          last;
      bit          done;
      bit          busy;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] wv[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000};

   task automatic add(input bit s, input bit r, input bit v, input logic [31:0] d,
                      input logic [2:0] ix, input bit l, input bit dn, input bit b);
      vec_t t;
      t.start = s; t.ready = r; t.valid = v; t.data = d; t.index = ix;
      t.last = l; t.done = dn; t.busy = b;
      vecs.push_back(t);
   endtask

   logic [31:0] got[5];
   int          ngot;
   logic [31:0] w;
   bit          any_busy, saw_done;

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b0; ready1 = 1'b0;
      result = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {out_valid, out_data, out_index, out_last, busy, done, overrun,
                          nan_flag}, '0);
      chk("reset_state1", {valid1, data1, index1, last1, busy1, done1, ovr1, nan1}, '0);
      rst = 1'b0;
      tick();

      // Job A: ready held high; job B: ready low for three cycles after word0 appears
      add(1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 1, 1, wv[i], 3'(i), i == 4, 0, 1);
      add(0, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, wv[0], 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 1, wv[0], 0, 0, 0, 1);
      for (int i = 1; i < 5; i++) add(0, 1, 1, wv[i], 3'(i), i == 4, 0, 1);
      add(0, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);

      result = {wv[0], wv[1], wv[2], wv[3], wv[4]};
      foreach (vecs[i]) begin
         start = vecs[i].start;
         out_ready = vecs[i].ready;
         tick();
         start = 1'b0;
         chk($sformatf("vec%0d_ctrl", i), {out_valid, busy, done, nan_flag},
             {vecs[i].valid, vecs[i].busy, vecs[i].done, 1'b0});
         if (vecs[i].valid)
            chk($sformatf("vec%0d_word", i), {out_data, out_index, out_last},
                {vecs[i].data, vecs[i].index, vecs[i].last});
      end

      // LATENCY=1 instance: capture one edge after start, word0 valid the cycle after
      start1 = 1'b1; ready1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("lat1_wait", {valid1, busy1}, 2'b01);
      tick();
      chk("lat1_word0", {valid1, data1, index1}, {1'b1, wv[0], 3'd0});
      repeat (4) tick();
      chk("lat1_word4", {valid1, data1, index1, last1}, {1'b1, wv[4], 3'd4, 1'b1});
      tick();
      chk("lat1_done", {valid1, done1, busy1}, 3'b010);

      // Overrun: second start three cycles in, start on the final handshake, result
      // changes after capture; the first job's words must be untouched
      start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ovr_pulse", overrun, 1);
      tick();
      chk("ovr_single", overrun, 0);
      ngot = 0;
      for (int k = 0; k < 30 && ngot < 5; k++) begin
         if (out_valid) begin
            if (out_last) start = 1'b1;
            got[ngot] = out_data;
            ngot++;
            result = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         end
         tick();
         start = 1'b0;
      end
      chk("ovr_word_count", ngot, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("ovr_word%0d", i), got[i], wv[i]);
      chk("ovr_on_last", {overrun, done, busy}, 3'b110);
      any_busy = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         any_busy |= busy;
      end
      chk("ovr_no_second_job", any_busy, 0);

      // Reset during SEND at word2
      result = {wv[0], wv[1], wv[2], wv[3], wv[4]};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid && out_index == 3'd2) break;
         tick();
      end
      chk("rst_reached_idx2", {out_valid, out_index}, {1'b1, 3'd2});
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      check_model();
      chk("rst_async", {out_valid, busy, out_index, done}, '0);
      tick();
      rst = 1'b0;
      saw_done = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         saw_done |= done;
      end
      chk("rst_no_done", saw_done, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk("rst_rerun_word0", {out_valid, out_data, out_index}, {1'b1, wv[0], 3'd0});
      for (int k = 0; k < 10 && busy; k++) tick();

      // NaN in word2: sticky through done, cleared by the next accepted start
      result = {wv[0], wv[1], 32'h7FC00000, wv[3], wv[4]};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk("nan_after_capture", nan_flag, NanEn);
      for (int k = 0; k < 10 && !done; k++) tick();
      chk("nan_at_done", {done, nan_flag}, {1'b1, NanEn});
      result = {wv[0], wv[1], wv[2], wv[3], wv[4]};
      repeat (2) tick();
      chk("nan_held_idle", nan_flag, NanEn);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("nan_cleared", nan_flag, 0);
      for (int k = 0; k < 30 && busy; k++) tick();

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         start = ($urandom_range(0, 12) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            for (int i = 0; i < 5; i++) begin
               w = $urandom();
               case ($urandom_range(0, 9))
                  0: w = {w[31], 8'hFF, w[22:1], 1'b1};
                  1: w = {w[31], 8'hFF, 23'd0};
                  default: ;
               endcase
               result[159-32*i -: 32] = w;
            end
         end
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0; start = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
